icache: RTL and testbench

Direct-mapped, one-word-per-frame instruction cache between the pipelined datapath's fetch port and the memory arbiter's instruction port. It answers hits combinationally in the same cycle. On a miss it runs a single-outstanding fill FSM against memory. The datapath advances its pipeline on ihit|dhit, so the fetch address may change during a fill; this block handles that case deterministically.

---
 rtl/icache.sv | 135 +++++++++++++
 tb/tb_icache.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
`timescale 1ns/1ps
// Direct-mapped, one-word-per-frame instruction cache: combinational hit path
// and a single-outstanding fill FSM towards the memory arbiter.
module icache #(
    parameter int unsigned NSETS   = 16,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        inval,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int unsigned IDX_W  = $clog2(NSETS);
    localparam int unsigned WORD_W = 30;
    localparam int unsigned TAG_W  = WORD_W - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state, next_state;

    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tags [NSETS];
    logic [31:0]       words [NSETS];
    logic              discard;
    logic [WORD_W-1:0] miss_word;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              start_fill;
    logic              fill_done;
    logic              fill_write;

    // Byte-offset bits and the reset PC are informational only.
    logic unused_bits;
    assign unused_bits = ^{imemaddr[1:0], PC_INIT};

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_word[IDX_W-1:0];
    assign fill_tag = miss_word[WORD_W-1:IDX_W];

    assign hit        = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
    assign start_fill = (state == IDLE) & imemREN & ~hit & ~inval;
    assign fill_done  = (state == FETCH) & ~iwait;
    // An invalidate seen at any point of the fill, including its last cycle, drops the write.
    assign fill_write = fill_done & ~discard & ~inval;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_fill) next_state = FETCH;
            FETCH:   if (!iwait)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Hits are only reported while idle; the fill owns the bus otherwise.
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        if (state == FETCH) begin
            iREN  = 1'b1;
            iaddr = {miss_word, 2'b00};
        end else if (hit) begin
            ihit     = 1'b1;
            imemload = words[req_idx];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (inval) begin
            valid <= '0;
        end else if (fill_write) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every read.
    always_ff @(posedge CLK) begin
        if (fill_write) begin
            tags[fill_idx]  <= fill_tag;
            words[fill_idx] <= iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_word <= '0;
            discard   <= 1'b0;
        end else if (start_fill) begin
            miss_word <= imemaddr[31:2];
            discard   <= 1'b0;
        end else if ((state == FETCH) && inval) begin
            discard <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt  <= 16'h0;
            miss_cnt <= 16'h0;
        end else begin
            if (ihit)       hit_cnt  <= hit_cnt + 16'd1;
            if (start_fill) miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_icache.sv
`timescale 1ns/1ps
// Self-checking bench for icache: a simple memory model answers fills and a
// scoreboard queue holds the instruction words each fetch must return.
module tb_icache;
    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        inval;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   exp_hits;
    int   exp_misses;
    int   wait_n;
    int   fetch_cnt;

    icache #(.NSETS(16), .PC_INIT(32'h0)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .inval    (inval),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Memory: holds iwait high for wait_n cycles of each request, then answers.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)               fetch_cnt <= 0;
        else if (iREN && iwait)  fetch_cnt <= fetch_cnt + 1;
        else                     fetch_cnt <= 0;
    end

    always_comb begin
        iwait = !(iREN && (fetch_cnt >= wait_n));
        iload = mem_data(iaddr);
    end

    task automatic check_counters(input string name);
        @(negedge CLK);
        imemREN = 1'b0;
        inval   = 1'b0;
        #1;
        checks++;
        if (hit_cnt !== 16'(exp_hits)) begin
            errors++;
            $display("FAIL %s hit_cnt: got %0d expected %0d", name, hit_cnt, 16'(exp_hits));
        end
        checks++;
        if (miss_cnt !== 16'(exp_misses)) begin
            errors++;
            $display("FAIL %s miss_cnt: got %0d expected %0d", name, miss_cnt, 16'(exp_misses));
        end
    endtask

    // Issue one fetch and hold it until ihit; checks bus address, fill length and returned word.
    task automatic do_fetch(input logic [31:0] addr, input int wn, input bit exp_miss, input string name);
        logic [31:0] waddr;
        int          fcyc;
        bit          got;
        exp_t        e;
        waddr = {addr[31:2], 2'b00};
        exp_q.push_back('{waddr, mem_data(waddr)});
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = addr;
        wait_n   = wn;
        fcyc     = 0;
        got      = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (ihit) begin
                got = 1'b1;
            end else if (iREN) begin
                fcyc++;
                checks++;
                if (iaddr !== waddr) begin
                    errors++;
                    $display("FAIL %s iaddr: got %h expected %h", name, iaddr, waddr);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no ihit within 40 cycles, expected data %h", name, e.data);
        end else if (imemload !== e.data) begin
            errors++;
            $display("FAIL %s imemload: got %h expected %h", name, imemload, e.data);
        end
        checks++;
        if (fcyc != (exp_miss ? wn + 1 : 0)) begin
            errors++;
            $display("FAIL %s fetch_cycles: got %0d expected %0d", name, fcyc, exp_miss ? wn + 1 : 0);
        end
        exp_hits++;
        if (exp_miss) exp_misses++;
    endtask

    task automatic test_reset;
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; inval = 1'b0; wait_n = 0;
        #12;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset_hit: got ihit=%b load=%h expected 0/0", ihit, imemload);
        end
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got iREN=%b iaddr=%h expected 0/0", iREN, iaddr);
        end
        checks++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
        end
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic test_basic_miss;
        do_fetch(32'h0, 2, 1'b1, "basic_miss_0x0");
        check_counters("basic_miss");
    endtask

    task automatic test_rehit;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{32'h0, mem_data(32'h0)});
            @(negedge CLK);
            imemREN  = 1'b1;
            imemaddr = 32'h0;
            #1;
            e = exp_q.pop_front();
            checks++;
            if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== e.data) begin
                errors++;
                $display("FAIL rehit[%0d]: got ihit=%b iREN=%b load=%h expected 1/0/%h",
                         i, ihit, iREN, imemload, e.data);
            end
        end
        exp_hits += 4;
        check_counters("rehit");
    endtask

    task automatic test_conflict;
        do_fetch(32'h40, 1, 1'b1, "conflict_0x40");
        do_fetch(32'h0, 0, 1'b1, "conflict_0x0_again");
        check_counters("conflict");
    endtask

    task automatic test_addr_change;
        int   fcyc;
        bit   got;
        exp_t e;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h8; wait_n = 2;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL chg_detect: got ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        exp_q.push_back('{32'h10, mem_data(32'h10)});
        @(negedge CLK);
        imemaddr = 32'h10;
        #1;
        fcyc = 0;
        for (int c = 0; c < 20 && iREN; c++) begin
            fcyc++;
            checks++;
            if (iaddr !== 32'h8) begin
                errors++;
                $display("FAIL chg_iaddr_hold: got %h expected %h", iaddr, 32'h8);
            end
            @(negedge CLK);
            #1;
        end
        checks++;
        if (fcyc != 3) begin
            errors++;
            $display("FAIL chg_fill_len: got %0d expected 3", fcyc);
        end
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL chg_new_detect: got ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        fcyc = 0;
        got  = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            #1;
            if (ihit) begin
                got = 1'b1;
            end else if (iREN) begin
                fcyc++;
                checks++;
                if (iaddr !== 32'h10) begin
                    errors++;
                    $display("FAIL chg_iaddr_new: got %h expected %h", iaddr, 32'h10);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!got || imemload !== e.data) begin
            errors++;
            $display("FAIL chg_hit_0x10: got ihit=%b load=%h expected 1/%h", got, imemload, e.data);
        end
        checks++;
        if (fcyc != 3) begin
            errors++;
            $display("FAIL chg_fill_len_new: got %0d expected 3", fcyc);
        end
        exp_misses += 2;
        exp_hits++;
        do_fetch(32'h8, 0, 1'b0, "chg_refetch_0x8");
        check_counters("addr_change");
    endtask

    task automatic test_no_ren;
        logic [31:0] addrs [2];
        addrs[0] = 32'h100;
        addrs[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            imemREN  = 1'b0;
            imemaddr = addrs[i % 2];
            #1;
            checks++;
            if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0) begin
                errors++;
                $display("FAIL no_ren[%0d]: got ihit=%b iREN=%b load=%h expected 0/0/0",
                         i, ihit, iREN, imemload);
            end
        end
        check_counters("no_ren");
        do_fetch(32'h3, 0, 1'b0, "byte_offset_0x3");
        do_fetch(32'h0, 0, 1'b0, "byte_offset_0x0");
    endtask

    task automatic test_min_latency;
        do_fetch(32'h14, 0, 1'b1, "min_latency_0x14");
        do_fetch(32'h14, 0, 1'b0, "min_latency_rehit");
        check_counters("min_latency");
    endtask

    task automatic test_inval;
        int fcyc;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h20; inval = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL inval_idle_hit: got %b expected 0", ihit);
        end
        @(negedge CLK);
        inval = 1'b0; imemREN = 1'b0;
        #1;
        checks++;
        if (iREN !== 1'b0) begin
            errors++;
            $display("FAIL inval_idle_no_fill: got iREN=%b expected 0", iREN);
        end
        check_counters("inval_idle");
        do_fetch(32'h8, 1, 1'b1, "inval_refill_0x8");

        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'hC; wait_n = 3;
        #1;
        @(negedge CLK);
        inval = 1'b1; imemREN = 1'b0;
        #1;
        fcyc = 0;
        for (int c = 0; c < 20 && iREN; c++) begin
            fcyc++;
            @(negedge CLK);
            inval = 1'b0;
            #1;
        end
        checks++;
        if (fcyc != 4) begin
            errors++;
            $display("FAIL inval_fill_len: got %0d expected 4", fcyc);
        end
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL inval_after_fill: got ihit=%b iREN=%b expected 0/0", ihit, iREN);
        end
        exp_misses++;
        do_fetch(32'hC, 0, 1'b1, "inval_discarded_0xC");
        do_fetch(32'h8, 0, 1'b1, "inval_prior_0x8");
        check_counters("inval");
    endtask

    task automatic test_reset_mid_fetch;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h4; wait_n = 5;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (iREN !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got iREN=%b expected 1", iREN);
        end
        #1;
        nRST = 1'b0;
        imemREN = 1'b0;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_bus: got iREN=%b iaddr=%h ihit=%b expected 0/0/0", iREN, iaddr, ihit);
        end
        checks++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
        end
        @(negedge CLK);
        nRST = 1'b1;
        exp_hits = 0;
        exp_misses = 0;
        do_fetch(32'h4, 0, 1'b1, "rst_mid_no_partial_0x4");
        check_counters("rst_mid");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_hits = 0;
        exp_misses = 0;
        test_reset();
        test_basic_miss();
        test_rehit();
        test_conflict();
        test_addr_change();
        test_no_ren();
        test_min_latency();
        test_inval();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
